mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- M-pipe stage directly downstream of the execute stage.
- Accepts one instruction per handshake from E: ALU/branch/CSR result, store data, destination register.
- Loads and stores become a single-beat request/response transaction on a data-memory port. Non-memory ops pass through a one-entry output register.
- Hands the write-back payload to the W-pipe with a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported (byte mask is 4 bits).
- REG_AW, 5, destination register index width (4 permitted for RV32E).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- E_valid_i  in  1  instruction valid from E-pipe.
- m_ready_o  out  1  stage can accept from E-pipe.
- is_load_i  in  1  instruction is a load.
- is_store_i  in  1  instruction is a store.
- funct3_i  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use [1:0]).
- res_i  in  XLEN  execute result; effective address for load/store.
- src2_i  in  XLEN  store data.
- pc_i  in  XLEN  instruction PC.
- rd_i  in  REG_AW  destination register.
- rd_wen_i  in  1  destination write enable.
- m_valid_o  out  1  write-back payload valid.
- W_ready_i  in  1  W-pipe accepts payload.
- wb_data_o  out  XLEN  write-back data.
- rd_o  out  REG_AW  destination register.
- rd_wen_o  out  1  destination write enable.
- pc_o  out  XLEN  instruction PC.
- misalign_o  out  1  access was misaligned; no memory transaction issued.
- req_valid_o  out  1  memory request valid.
- req_ready_i  in  1  memory accepts request.
- req_addr_o  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
- req_wen_o  out  1  1 = write.
- req_wdata_o  out  XLEN  lane-shifted store data.
- req_wmask_o  out  4  byte-lane strobes.
- rsp_valid_i  in  1  response valid.
- rsp_rdata_i  in  XLEN  read data (whole word).
- rsp_ready_o  out  1  stage accepts response.

Behaviour:
- States: IDLE, REQ, RESP, HOLD. Reset state IDLE.
- Reset values: all outputs 0; payload registers 0.
- m_ready_o = (state==IDLE) | (state==HOLD & W_ready_i). This is combinational from W_ready_i.
- Accept occurs when E_valid_i & m_ready_o. On accept, latch res/src2/pc/rd/rd_wen/funct3/load/store. Next state:
  - misaligned load/store (half with addr[0]=1, word with addr[1:0]!=0) → HOLD, misalign_o=1, rd_wen_o=0;
  - aligned load/store → REQ;
  - otherwise → HOLD, wb_data_o=res_i, rd_wen_o=rd_wen_i. One-cycle latency.
- REQ: req_valid_o=1. Address, wen, wdata and wmask stay stable until req_ready_i. On req_ready_i → RESP.
- RESP: rsp_ready_o=1. On rsp_valid_i → HOLD.
  - Load: wb_data_o = rsp_rdata_i >> (8*addr[1:0]), then sign- or zero-extended per funct3.
  - Store: rd_wen_o=0, wb_data_o=0.
- rsp_valid_i outside RESP is ignored (rsp_ready_o=0). A request and its response cannot occur in the same cycle.
- Store lanes:
  - SB: mask 0001<<addr[1:0], data = byte replicated ×4.
  - SH: mask 0011<<addr[1:0], data = half replicated ×2.
  - SW: mask 1111, data unchanged.
- HOLD: m_valid_o=1, payload stable until W_ready_i.
  - On W_ready_i without a new accept → IDLE.
  - With a simultaneous accept → new instruction's next state per the accept rule. Back-to-back non-memory ops sustain one per cycle.
- m_valid_o is 1 only in HOLD. E_valid_i is ignored in REQ/RESP.
- Asynchronous reset mid-transaction forces IDLE and drops the in-flight op. The memory port shares rst_n_i, so no orphan response is expected.

Test Plan:
- Reset then ALU op: res_i=0x1234, rd=5, wen=1, W_ready_i=1 → next cycle m_valid_o=1, wb_data_o=0x1234, rd_o=5. Three back-to-back ops retire at 1/cycle.
- LB at addr 0x1003, rsp_rdata_i=0x80FFEEDD, req_ready_i delayed 2 cycles:
  - req_addr_o=0x1000 held stable throughout;
  - wb_data_o=0xFFFFFF80;
  - the same access as LBU gives 0x00000080.
- SH at 0x2002 with src2=0xABCD1234 → req_wen_o=1, req_wmask_o=1100, req_wdata_o=0x12341234; store completes with rd_wen_o=0.
- LW at 0x3001 → no req_valid_o pulse, m_valid_o next cycle with misalign_o=1, rd_wen_o=0.
- HOLD with W_ready_i=0 for 3 cycles → payload stable, m_ready_o=0. E_valid_i is then held high and W_ready_i rises: the held payload retires and the new op is accepted in the same cycle.
- rst_n_i asserted during RESP → outputs 0 immediately, state IDLE; a later rsp_valid_i is ignored and m_valid_o stays 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipe stage between execute and write-back: issues single-beat data-memory
// transactions for loads/stores and registers a write-back payload for the W-pipe.
module mem_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              E_valid_i,
    output logic              m_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   res_i,
    input  logic [XLEN-1:0]   src2_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              rd_wen_i,
    output logic              m_valid_o,
    input  logic              W_ready_i,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              rd_wen_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              misalign_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [XLEN-1:0]   req_addr_o,
    output logic              req_wen_o,
    output logic [XLEN-1:0]   req_wdata_o,
    output logic [3:0]        req_wmask_o,
    input  logic              rsp_valid_i,
    input  logic [XLEN-1:0]   rsp_rdata_i,
    output logic              rsp_ready_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      funct3_q;
    logic            is_load_q;

    logic            accept;
    logic            is_mem;
    logic            misalign;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;

    // HOLD can take a new op in the same cycle its payload retires
    assign m_ready_o   = (state == IDLE) | ((state == HOLD) & W_ready_i);
    assign accept      = E_valid_i & m_ready_o;
    assign m_valid_o   = (state == HOLD);
    assign req_valid_o = (state == REQ);
    assign rsp_ready_o = (state == RESP);
    assign req_addr_o  = {addr_q[XLEN-1:2], 2'b00};

    assign is_mem   = is_load_i | is_store_i;
    assign misalign = is_mem & (((funct3_i[1:0] == 2'b01) & res_i[0]) |
                                ((funct3_i[1:0] == 2'b10) & (res_i[1:0] != 2'b00)));

    always_comb begin
        st_mask = 4'b1111;
        st_data = src2_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_mask = 4'b0001 << res_i[1:0];
                st_data = {4{src2_i[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << res_i[1:0];
                st_data = {2{src2_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = rsp_rdata_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            wb_data_o   <= '0;
            rd_o        <= '0;
            rd_wen_o    <= 1'b0;
            pc_o        <= '0;
            misalign_o  <= 1'b0;
            req_wen_o   <= 1'b0;
            req_wdata_o <= '0;
            req_wmask_o <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        addr_q      <= res_i;
                        funct3_q    <= funct3_i;
                        is_load_q   <= is_load_i;
                        pc_o        <= pc_i;
                        rd_o        <= rd_i;
                        wb_data_o   <= res_i;
                        misalign_o  <= misalign;
                        req_wen_o   <= is_store_i & ~is_load_i;
                        req_wmask_o <= (is_store_i & ~is_load_i) ? st_mask : 4'b0000;
                        req_wdata_o <= st_data;
                        if (misalign) begin
                            state    <= HOLD;
                            rd_wen_o <= 1'b0;
                        end else if (is_mem) begin
                            state    <= REQ;
                            rd_wen_o <= rd_wen_i & is_load_i;
                        end else begin
                            state    <= HOLD;
                            rd_wen_o <= rd_wen_i;
                        end
                    end else if ((state == HOLD) && W_ready_i) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (req_ready_i) state <= RESP;
                end
                RESP: begin
                    if (rsp_valid_i) begin
                        state     <= HOLD;
                        wb_data_o <= is_load_q ? ld_data : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-back payloads into a
// scoreboard queue; a monitor pops and compares whenever a payload retires.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        e_valid;
    logic        m_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] res;
    logic [31:0] src2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        m_valid;
    logic        w_ready;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        rd_wen_out;
    logic [31:0] pc_out;
    logic        misalign;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_ready;

    mem_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .E_valid_i   (e_valid),
        .m_ready_o   (m_ready),
        .is_load_i   (is_load),
        .is_store_i  (is_store),
        .funct3_i    (funct3),
        .res_i       (res),
        .src2_i      (src2),
        .pc_i        (pc),
        .rd_i        (rd),
        .rd_wen_i    (rd_wen),
        .m_valid_o   (m_valid),
        .W_ready_i   (w_ready),
        .wb_data_o   (wb_data),
        .rd_o        (rd_out),
        .rd_wen_o    (rd_wen_out),
        .pc_o        (pc_out),
        .misalign_o  (misalign),
        .req_valid_o (req_valid),
        .req_ready_i (req_ready),
        .req_addr_o  (req_addr),
        .req_wen_o   (req_wen),
        .req_wdata_o (req_wdata),
        .req_wmask_o (req_wmask),
        .rsp_valid_i (rsp_valid),
        .rsp_rdata_i (rsp_rdata),
        .rsp_ready_o (rsp_ready)
    );

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] pc;
        logic        mis;
        logic        chk_wb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                         input logic [4:0] r, input logic w);
        e_valid  = 1'b1;
        is_load  = ld;
        is_store = st;
        funct3   = f3;
        res      = a;
        src2     = d;
        pc       = p;
        rd       = r;
        rd_wen   = w;
    endtask

    task automatic push(input logic [31:0] wb, input logic [4:0] r, input logic w,
                        input logic [31:0] p, input logic mis, input logic chk_wb);
        exp_t e;
        e.wb = wb; e.rd = r; e.wen = w; e.pc = p; e.mis = mis; e.chk_wb = chk_wb;
        sb.push_back(e);
    endtask

    // Full load/store transaction with req_ready held off for dly cycles
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                          input logic [4:0] r, input logic [31:0] rdata, input int unsigned dly,
                          input logic [31:0] exp_wb, input logic exp_wen,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        w_ready = 1'b1;
        drive(ld, st, f3, a, d, p, r, 1'b1);
        #1;
        chk({tag, "_m_ready"}, 32'(m_ready), 32'd1);
        step();
        e_valid = 1'b0;
        chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
        chk({tag, "_req_addr"}, req_addr, {a[31:2], 2'b00});
        chk({tag, "_req_wen"}, 32'(req_wen), 32'(st));
        if (st) begin
            chk({tag, "_req_wmask"}, 32'(req_wmask), 32'(exp_mask));
            chk({tag, "_req_wdata"}, req_wdata, exp_wdata);
        end
        for (int unsigned i = 0; i < dly; i++) begin
            step();
            chk({tag, "_req_hold_valid"}, 32'(req_valid), 32'd1);
            chk({tag, "_req_hold_addr"}, req_addr, {a[31:2], 2'b00});
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk({tag, "_rsp_ready"}, 32'(rsp_ready), 32'd1);
        chk({tag, "_req_dropped"}, 32'(req_valid), 32'd0);
        push(exp_wb, r, exp_wen, p, 1'b0, 1'b1);
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        step();
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd1);
        step();
    endtask

    // Scoreboard monitor: a payload retires when m_valid and W_ready meet at an edge
    always @(negedge clk) begin
        if (rst_n && m_valid && w_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_retire: got wb %h rd %0d, expected no payload", wb_data, rd_out);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_rd", 32'(rd_out), 32'(mon_e.rd));
                chk("sb_rd_wen", 32'(rd_wen_out), 32'(mon_e.wen));
                chk("sb_pc", pc_out, mon_e.pc);
                chk("sb_misalign", 32'(misalign), 32'(mon_e.mis));
                if (mon_e.chk_wb) chk("sb_wb_data", wb_data, mon_e.wb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; e_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        res = 32'h0; src2 = 32'h0; pc = 32'h0; rd = 5'd0; rd_wen = 1'b0;
        w_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
        step();
        step();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_rd_wen", 32'(rd_wen_out), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_m_ready_idle", 32'(m_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Three back-to-back ALU ops retiring one per cycle
        w_ready = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h10, 5'd5, 1'b1);
        push(32'h1234, 5'd5, 1'b1, 32'h10, 1'b0, 1'b1);
        step();
        chk("alu1_m_valid", 32'(m_valid), 32'd1);
        chk("alu1_wb_data", wb_data, 32'h1234);
        chk("alu1_rd", 32'(rd_out), 32'd5);
        drive(1'b0, 1'b0, 3'b000, 32'h2222, 32'h0, 32'h14, 5'd6, 1'b1);
        #1;
        chk("alu2_m_ready", 32'(m_ready), 32'd1);
        push(32'h2222, 5'd6, 1'b1, 32'h14, 1'b0, 1'b1);
        step();
        chk("alu2_wb_data", wb_data, 32'h2222);
        drive(1'b0, 1'b0, 3'b000, 32'h3333, 32'h0, 32'h18, 5'd7, 1'b0);
        push(32'h3333, 5'd7, 1'b0, 32'h18, 1'b0, 1'b1);
        step();
        e_valid = 1'b0;
        chk("alu3_m_valid", 32'(m_valid), 32'd1);
        chk("alu3_wb_data", wb_data, 32'h3333);
        step();
        chk("alu_idle_m_valid", 32'(m_valid), 32'd0);

        // LB / LBU at 0x1003, top byte 0x80
        mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h100, 5'd8,
               32'h80FFEEDD, 2, 32'hFFFFFF80, 1'b1, 4'b0000, 32'h0);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h104, 5'd9,
               32'h80FFEEDD, 0, 32'h00000080, 1'b1, 4'b0000, 32'h0);
        mem_op("lh", 1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 32'h106, 5'd11,
               32'h80FFEEDD, 1, 32'hFFFF80FF, 1'b1, 4'b0000, 32'h0);
        // SH at 0x2002: upper half lanes, half replicated
        mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h2002, 32'hABCD1234, 32'h108, 5'd10,
               32'hDEADBEEF, 1, 32'h0, 1'b0, 4'b1100, 32'h12341234);
        mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h2001, 32'hABCD1234, 32'h10C, 5'd12,
               32'hDEADBEEF, 0, 32'h0, 1'b0, 4'b0010, 32'h34343434);

        // Misaligned LW: no memory request, flagged payload next cycle
        drive(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h200, 5'd3, 1'b1);
        push(32'h0, 5'd3, 1'b0, 32'h200, 1'b1, 1'b0);
        step();
        e_valid = 1'b0;
        chk("mis_req_valid", 32'(req_valid), 32'd0);
        chk("mis_m_valid", 32'(m_valid), 32'd1);
        chk("mis_flag", 32'(misalign), 32'd1);
        step();
        chk("mis_req_valid_after", 32'(req_valid), 32'd0);

        // Stall in HOLD for three cycles, then retire and accept in one cycle
        w_ready = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h55AA, 32'h0, 32'h300, 5'd9, 1'b1);
        push(32'h55AA, 5'd9, 1'b1, 32'h300, 1'b0, 1'b1);
        step();
        e_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_m_valid", 32'(m_valid), 32'd1);
            chk("stall_m_ready", 32'(m_ready), 32'd0);
            chk("stall_wb_data", wb_data, 32'h55AA);
            chk("stall_rd", 32'(rd_out), 32'd9);
            step();
        end
        drive(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 32'h304, 5'd10, 1'b1);
        #1;
        chk("stall_e_valid_blocked", 32'(m_ready), 32'd0);
        w_ready = 1'b1;
        #1;
        chk("release_m_ready", 32'(m_ready), 32'd1);
        push(32'h77, 5'd10, 1'b1, 32'h304, 1'b0, 1'b1);
        step();
        e_valid = 1'b0;
        chk("overlap_m_valid", 32'(m_valid), 32'd1);
        chk("overlap_wb_data", wb_data, 32'h77);
        step();

        // Reset asserted while waiting for a response
        drive(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h400, 5'd4, 1'b1);
        step();
        e_valid = 1'b0;
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("rstmid_rsp_ready_before", 32'(rsp_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rstmid_m_valid", 32'(m_valid), 32'd0);
        chk("rstmid_req_addr", req_addr, 32'd0);
        chk("rstmid_pc", pc_out, 32'd0);
        chk("rstmid_m_ready", 32'(m_ready), 32'd1);
        step();
        rst_n = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_m_valid", 32'(m_valid), 32'd0);
            chk("post_rst_rsp_ready", 32'(rsp_ready), 32'd0);
        end
        rsp_valid = 1'b0;
        step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
